c1_master: RTL and testbench

Synthesizable CPU-side master for the C1 bus between the processor model and the L1 cache. Replaces the hand-sequenced testbench driving: accepts word-level requests from a core through a valid/ready queue and serialises each into the two-tick C1 address/command phase. It then releases the bus, waits for the cache's response code and collects one or two data beats. It returns read data or completion on a one-cycle response strobe.

---
 rtl/c1_master_if.sv | 26 ++
 rtl/c1_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_c1_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/c1_master_if.sv
// Core-side request/response bundle for c1_master.
// The master modport is the core; the slave modport is the C1 bus master block.
interface c1_master_if #(
  parameter int unsigned MEM_ADDR_SIZE = 19,
  parameter int unsigned BUS_SIZE      = 16
) ();
  logic                       req_valid;
  logic                       req_ready;
  logic [2:0]                 req_cmd;
  logic [MEM_ADDR_SIZE-1:0]   req_addr;
  logic [2*BUS_SIZE-1:0]      req_wdata;
  logic                       rsp_valid;
  logic [2*BUS_SIZE-1:0]      rsp_data;
  logic                       rsp_error;
  logic                       busy;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_error, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_error, busy
  );
endinterface

// File: rtl/c1_master.sv
// CPU-side C1 bus master: request FIFO, two-tick address phase, response collection.
// Optional WAIT watchdog enabled by defining C1_MASTER_TIMEOUT_EN.
module c1_master #(
  parameter int unsigned MEM_ADDR_SIZE     = 19,
  parameter int unsigned BUS_SIZE          = 16,
  parameter int unsigned CACHE_OFFSET_SIZE = 4,
  parameter int unsigned QUEUE_DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  c1_master_if.slave                                   core,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0]   address,
  inout  wire  [BUS_SIZE-1:0]                          data,
  inout  wire  [2:0]                                   command
);
  localparam int unsigned ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int unsigned RSP_W  = 2 * BUS_SIZE;
  localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_READ8   = 3'd1;
  localparam logic [2:0] CMD_READ16  = 3'd2;
  localparam logic [2:0] CMD_READ32  = 3'd3;
  localparam logic [2:0] CMD_WRITE8  = 3'd5;
  localparam logic [2:0] CMD_WRITE32 = 3'd7;
  localparam logic [2:0] C1_RESPONSE = 3'd7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR1 = 3'd1;
  localparam logic [2:0] S_ADDR2 = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RD2   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  typedef struct packed {
    logic [2:0]               cmd;
    logic [MEM_ADDR_SIZE-1:0] addr;
    logic [RSP_W-1:0]         wdata;
  } req_t;

  function automatic logic is_write(input logic [2:0] c);
    return c >= CMD_WRITE8;
  endfunction

  // Request FIFO
  req_t             mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;
  req_t             head, in_req;

  assign full   = (cnt_q == CNT_W'(QUEUE_DEPTH));
  assign empty  = (cnt_q == '0);
  assign push   = core.req_valid && !full;
  assign head   = mem_q[rd_ptr_q];
  assign in_req = '{cmd: core.req_cmd, addr: core.req_addr, wdata: core.req_wdata};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_req;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Transaction state
  logic [2:0]                   state_q, state_d;
  logic [2:0]                   cur_cmd_q, cur_cmd_d;
  logic [CACHE_OFFSET_SIZE-1:0] cur_off_q, cur_off_d;
  logic [BUS_SIZE-1:0]          cur_whi_q, cur_whi_d;
  logic [ADDR_W-1:0]            address_q, address_d;
  logic [2:0]                   cmd_q, cmd_d;
  logic                         cmd_oe_q, cmd_oe_d;
  logic [BUS_SIZE-1:0]          data_q, data_d;
  logic                         data_oe_q, data_oe_d;
  logic [RSP_W-1:0]             rdata_q, rdata_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]             rsp_data_q, rsp_data_d;
`ifdef C1_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0]             tmo_q, tmo_d;
  logic                         rsp_error_q, rsp_error_d;
`else
  logic                         unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin : fsm_comb
    state_d     = state_q;
    cur_cmd_d   = cur_cmd_q;
    cur_off_d   = cur_off_q;
    cur_whi_d   = cur_whi_q;
    address_d   = address_q;
    cmd_d       = cmd_q;
    cmd_oe_d    = 1'b0;
    data_d      = data_q;
    data_oe_d   = 1'b0;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
`ifdef C1_MASTER_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_error_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cur_cmd_d = head.cmd;
          cur_off_d = head.addr[CACHE_OFFSET_SIZE-1:0];
          cur_whi_d = head.wdata[RSP_W-1:BUS_SIZE];
          if (head.cmd == CMD_NOP) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d   = S_ADDR1;
            address_d = head.addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
            cmd_d     = head.cmd;
            cmd_oe_d  = 1'b1;
            data_d    = head.wdata[BUS_SIZE-1:0];
            data_oe_d = is_write(head.cmd);
          end
        end
      end
      S_ADDR1: begin
        state_d   = S_ADDR2;
        address_d = ADDR_W'(cur_off_q);
        cmd_oe_d  = 1'b1;
        data_d    = cur_whi_q;
        data_oe_d = (cur_cmd_q == CMD_WRITE32);
      end
      S_ADDR2: state_d = S_TURN;
      S_TURN: begin
        state_d = S_WAIT;
`ifdef C1_MASTER_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (command == C1_RESPONSE) begin
          rdata_d[BUS_SIZE-1:0] = data;
          state_d = (cur_cmd_q == CMD_READ32) ? S_RD2 : S_DONE;
`ifdef C1_MASTER_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_RD2: begin
        rdata_d[RSP_W-1:BUS_SIZE] = data;
        state_d = S_DONE;
`ifdef C1_MASTER_TIMEOUT_EN
        tmo_d   = tmo_q + TMO_W'(1);
`endif
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
        case (cur_cmd_q)
          CMD_READ8:  rsp_data_d = RSP_W'(rdata_q[7:0]);
          CMD_READ16: rsp_data_d = RSP_W'(rdata_q[BUS_SIZE-1:0]);
          CMD_READ32: rsp_data_d = rdata_q;
          default:    rsp_data_d = '0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      cur_cmd_q   <= '0;
      cur_off_q   <= '0;
      cur_whi_q   <= '0;
      address_q   <= '0;
      cmd_q       <= '0;
      cmd_oe_q    <= 1'b0;
      data_q      <= '0;
      data_oe_q   <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef C1_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cur_cmd_q   <= cur_cmd_d;
      cur_off_q   <= cur_off_d;
      cur_whi_q   <= cur_whi_d;
      address_q   <= address_d;
      cmd_q       <= cmd_d;
      cmd_oe_q    <= cmd_oe_d;
      data_q      <= data_d;
      data_oe_q   <= data_oe_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef C1_MASTER_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  // Bus drivers are enabled only by registered ADDR1/ADDR2 enables
  assign command = cmd_oe_q  ? cmd_q  : 'z;
  assign data    = data_oe_q ? data_q : 'z;
  assign address = address_q;

  assign core.req_ready = !full;
  assign core.busy      = (state_q != S_IDLE) || !empty;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_data  = rsp_data_q;
`ifdef C1_MASTER_TIMEOUT_EN
  assign core.rsp_error = rsp_error_q;
`else
  assign core.rsp_error = 1'b0;
`endif
endmodule

// File: tb/tb_c1_master.sv
// Directed bench for c1_master; the C1 bus has a pull-up on data and pull-down on command
// so a released bus reads as data=FFFF, command=0.
module tb_c1_master;
  localparam int unsigned MEM_ADDR_SIZE     = 19;
  localparam int unsigned BUS_SIZE          = 16;
  localparam int unsigned CACHE_OFFSET_SIZE = 4;

  logic        clk;
  logic        rst_n;
  logic        tb_oe;
  logic [2:0]  tb_cmd;
  logic [15:0] tb_data;
  wire  [14:0] address;
  wire  [15:0] data;
  wire  [2:0]  command;

  int total = 0;
  int bad   = 0;

  c1_master_if #(.MEM_ADDR_SIZE(MEM_ADDR_SIZE), .BUS_SIZE(BUS_SIZE)) core_if ();

  c1_master #(
    .MEM_ADDR_SIZE(MEM_ADDR_SIZE), .BUS_SIZE(BUS_SIZE), .CACHE_OFFSET_SIZE(CACHE_OFFSET_SIZE),
    .QUEUE_DEPTH(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core(core_if), .address(address), .data(data), .command(command)
  );

  assign data    = tb_oe ? tb_data : 'z;
  assign command = tb_oe ? tb_cmd  : 'z;
  pullup   (data);
  pulldown (command);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic [18:0] a, input logic [31:0] w);
    core_if.req_cmd   = c;
    core_if.req_addr  = a;
    core_if.req_wdata = w;
    core_if.req_valid = 1'b1;
    for (int n = 0; n < 50 && !core_if.req_ready; n++) tick();
    check("push_ready", 32'(core_if.req_ready), 32'd1);
    tick();
    core_if.req_valid = 1'b0;
  endtask

  task automatic wait_addr1(input string tag, input int max_wait);
    int n = 0;
    while (command == 3'd0 && n < max_wait) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(command != 3'd0), 32'd1);
  endtask

  // Entry: ADDR1 is on the bus. Walks ADDR2/TURN/WAIT, answers and checks the response.
  task automatic serve(input string tag, input logic [2:0] c, input logic [31:0] a1, a2, d1, d2,
                       input int gap, input logic [15:0] b0, b1, input logic [31:0] exp_rsp);
    check({tag, "_a1_addr"}, 32'(address), a1);
    check({tag, "_a1_cmd"},  32'(command), 32'(c));
    check({tag, "_a1_data"}, 32'(data), d1);
    tick();
    check({tag, "_a2_addr"}, 32'(address), a2);
    check({tag, "_a2_cmd"},  32'(command), 32'(c));
    check({tag, "_a2_data"}, 32'(data), d2);
    tick();
    check({tag, "_turn_cmd"},  32'(command), 32'd0);
    check({tag, "_turn_data"}, 32'(data), 32'h0000FFFF);
    check({tag, "_turn_addr"}, 32'(address), a2);
    tick();
    repeat (gap) tick();
    tb_oe = 1'b1; tb_cmd = 3'd7; tb_data = b0;
    tick();
    if (c == 3'd3) begin
      tb_data = b1;
      tick();
    end
    tb_oe = 1'b0;
    check({tag, "_rsp_early"}, 32'(core_if.rsp_valid), 32'd0);
    tick();
    check({tag, "_rsp_valid"}, 32'(core_if.rsp_valid), 32'd1);
    check({tag, "_rsp_data"},  core_if.rsp_data, exp_rsp);
    check({tag, "_rsp_err"},   32'(core_if.rsp_error), 32'd0);
    tick();
    check({tag, "_rsp_pulse"}, 32'(core_if.rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; tb_oe = 1'b0; tb_cmd = '0; tb_data = '0;
    core_if.req_valid = 1'b0; core_if.req_cmd = '0; core_if.req_addr = '0; core_if.req_wdata = '0;
    #12;
    check("rst_rsp_valid", 32'(core_if.rsp_valid), 32'd0);
    check("rst_rsp_data",  core_if.rsp_data, 32'd0);
    check("rst_rsp_err",   32'(core_if.rsp_error), 32'd0);
    check("rst_busy",      32'(core_if.busy), 32'd0);
    check("rst_ready",     32'(core_if.req_ready), 32'd1);
    check("rst_addr",      32'(address), 32'd0);
    check("rst_cmd_z",     32'(command), 32'd0);
    check("rst_data_z",    32'(data), 32'h0000FFFF);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed single transactions
    push(3'd1, 19'h00013, 32'h0);
    wait_addr1("rd8", 1);
    check("rd8_busy", 32'(core_if.busy), 32'd1);
    serve("rd8", 3'd1, 32'h001, 32'h003, 32'hFFFF, 32'hFFFF, 1, 16'hBEEF, 16'h0, 32'h000000EF);

    push(3'd7, 19'h7FFF0, 32'hCAFE1234);
    wait_addr1("wr32", 1);
    serve("wr32", 3'd7, 32'h7FFF, 32'h0, 32'h1234, 32'hCAFE, 0, 16'h0000, 16'h0, 32'h0);

    push(3'd3, 19'h00120, 32'h0);
    wait_addr1("rd32", 1);
    serve("rd32", 3'd3, 32'h012, 32'h0, 32'hFFFF, 32'hFFFF, 2, 16'h5678, 16'h9ABC, 32'h9ABC5678);

    push(3'd0, 19'h00000, 32'h0);
    check("nop_no_rsp_yet", 32'(core_if.rsp_valid), 32'd0);
    tick();
    check("nop_rsp_valid", 32'(core_if.rsp_valid), 32'd1);
    check("nop_rsp_data",  core_if.rsp_data, 32'd0);
    check("nop_no_bus",    32'(command), 32'd0);
    tick();
    check("nop_pulse", 32'(core_if.rsp_valid), 32'd0);

    push(3'd2, 19'h1234A, 32'h0);
    wait_addr1("rd16", 1);
    serve("rd16", 3'd2, 32'h1234, 32'hA, 32'hFFFF, 32'hFFFF, 0, 16'hA55A, 16'h0, 32'h0000A55A);

    push(3'd5, 19'h00005, 32'h000000AB);
    wait_addr1("wr8", 1);
    serve("wr8", 3'd5, 32'h0, 32'h5, 32'h00AB, 32'hFFFF, 0, 16'h0000, 16'h0, 32'h0);

    // Queue fill while the cache stalls on A
    push(3'd2, 19'h00100, 32'h0);
    push(3'd1, 19'h00211, 32'h0);
    push(3'd6, 19'h00330, 32'h00003333);
    push(3'd3, 19'h00440, 32'h0);
    check("q_ready_before_4th", 32'(core_if.req_ready), 32'd1);
    push(3'd2, 19'h00550, 32'h0);
    check("q_ready_full", 32'(core_if.req_ready), 32'd0);
    core_if.req_cmd = 3'd5; core_if.req_addr = 19'h00661; core_if.req_wdata = 32'h00000077;
    core_if.req_valid = 1'b1;
    tick();
    tick();
    check("q_5th_blocked", 32'(core_if.req_ready), 32'd0);
    tb_oe = 1'b1; tb_cmd = 3'd7; tb_data = 16'h1111;
    tick();
    tb_oe = 1'b0;
    tick();
    check("qa_rsp_valid", 32'(core_if.rsp_valid), 32'd1);
    check("qa_rsp_data",  core_if.rsp_data, 32'h00001111);
    check("q_still_full", 32'(core_if.req_ready), 32'd0);
    tick();
    check("q_space_freed", 32'(core_if.req_ready), 32'd1);
    fork
      serve("qb", 3'd1, 32'h021, 32'h1, 32'hFFFF, 32'hFFFF, 0, 16'h22F2, 16'h0, 32'h000000F2);
      begin
        tick();
        core_if.req_valid = 1'b0;
        check("q_5th_accepted", 32'(core_if.req_ready), 32'd0);
      end
    join
    wait_addr1("qc", 2);
    serve("qc", 3'd6, 32'h033, 32'h0, 32'h3333, 32'hFFFF, 0, 16'h0000, 16'h0, 32'h0);
    wait_addr1("qd", 2);
    serve("qd", 3'd3, 32'h044, 32'h0, 32'hFFFF, 32'hFFFF, 1, 16'h4444, 16'h5555, 32'h55554444);
    wait_addr1("qe", 2);
    serve("qe", 3'd2, 32'h055, 32'h0, 32'hFFFF, 32'hFFFF, 0, 16'h6666, 16'h0, 32'h00006666);
    wait_addr1("qf", 2);
    serve("qf", 3'd5, 32'h066, 32'h1, 32'h0077, 32'hFFFF, 0, 16'h0000, 16'h0, 32'h0);
    check("q_idle", 32'(core_if.busy), 32'd0);

    // Reset while driving the bus in ADDR1
    push(3'd6, 19'h00040, 32'h0000BEAD);
    tick();
    check("rsta1_data_driven", 32'(data), 32'h0000BEAD);
    #2 rst_n = 1'b0;
    #1;
    check("rsta1_data_z", 32'(data), 32'h0000FFFF);
    check("rsta1_cmd_z",  32'(command), 32'd0);
    check("rsta1_addr",   32'(address), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Reset during WAIT with requests still queued
    push(3'd1, 19'h00100, 32'h0);
    push(3'd2, 19'h00200, 32'h0);
    push(3'd1, 19'h00300, 32'h0);
    tick();
    tick();
    check("rstw_busy_pre", 32'(core_if.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_busy",  32'(core_if.busy), 32'd0);
    check("rstw_ready", 32'(core_if.req_ready), 32'd1);
    check("rstw_rsp",   32'(core_if.rsp_valid), 32'd0);
    check("rstw_cmd_z", 32'(command), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rstw_no_rsp", 32'(core_if.rsp_valid), 32'd0);
    end
    check("rstw_discarded", 32'(core_if.busy), 32'd0);
    check("rstw_bus_idle",  32'(command), 32'd0);

`ifdef C1_MASTER_TIMEOUT_EN
    // No cache response: error strobe 10 cycles after WAIT entry, then next request runs
    push(3'd2, 19'h00700, 32'h0);
    push(3'd1, 19'h00811, 32'h0);
    check("tmo_addr1", 32'(address), 32'h070);
    tick();
    tick();
    tick();
    repeat (9) tick();
    check("tmo_not_yet", 32'(core_if.rsp_valid), 32'd0);
    tick();
    check("tmo_rsp_valid", 32'(core_if.rsp_valid), 32'd1);
    check("tmo_rsp_err",   32'(core_if.rsp_error), 32'd1);
    check("tmo_rsp_data",  core_if.rsp_data, 32'd0);
    wait_addr1("tmo_next", 2);
    serve("tmo_next", 3'd1, 32'h081, 32'h1, 32'hFFFF, 32'hFFFF, 0, 16'h0099, 16'h0, 32'h00000099);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
